// File: rtl/imem_boot_loader_pkg.sv
// Shared loader definitions: state encoding, byte/instruction widths, default PC stride
// and core reset polarity. State ST_CHK exists only when BOOT_LOADER_CHECKSUM_EN is defined.
package imem_boot_loader_pkg;

    localparam int   BYTE_W            = 8;
    localparam int   INSTR_W           = 16;
    localparam int   DEFAULT_PC_STRIDE = 4;
    localparam logic CORE_RST_ACTIVE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd5,
`endif
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // States in which the loader is mid-load and consumes stream bytes.
    function automatic logic is_loading(input state_t s);
        logic r;
        r = (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) || (s == ST_DAT_LO);
`ifdef BOOT_LOADER_CHECKSUM_EN
        r = r || (s == ST_CHK);
`endif
        return r;
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs a high byte and the following low byte into one instruction word,
// emitting a single-cycle word_valid in the cycle after the low byte arrives.
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hi_load,
    input  logic               lo_load,
    input  logic [BYTE_W-1:0]  rx_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [BYTE_W-1:0] hi_byte;
    logic              have_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte    <= '0;
            have_hi    <= 1'b0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (hi_load) begin
                hi_byte <= rx_byte;
                have_hi <= 1'b1;
            end
            if (lo_load && have_hi) begin
                word       <= {hi_byte, rx_byte};
                word_valid <= 1'b1;
                have_hi    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: writes a length-prefixed program into instruction memory and
// holds the core in reset until it is loaded. BOOT_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          MAX_WORDS  = 256,
    parameter logic [15:0] START_ADDR = 16'h0,
    parameter int          PC_STRIDE  = DEFAULT_PC_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [15:0]        imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        word_count
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = ST_CHK;
`else
    localparam state_t AFTER_DATA = ST_DONE;
`endif

    state_t            state;
    state_t            next_state;
    logic [BYTE_W-1:0] len_hi;
    logic [15:0]       words_left;
    logic [15:0]       len_value;
    logic              accept;
    logic              start_ok;
    logic              hi_load;
    logic              lo_load;
    logic              word_valid;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign rx_ready  = is_loading(state);
    assign busy      = is_loading(state);
    assign accept    = rx_valid && rx_ready;
    assign len_value = {len_hi, rx_data};
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign hi_load   = accept && (state == ST_DAT_HI);
    assign lo_load   = accept && (state == ST_DAT_LO);
    assign imem_we   = word_valid;

    imem_boot_loader_word_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .hi_load    (hi_load),
        .lo_load    (lo_load),
        .rx_byte    (rx_data),
        .word_valid (word_valid),
        .word       (imem_wdata)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_LEN_HI;
            ST_LEN_HI: if (accept) next_state = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_value == 16'd0)
                        next_state = AFTER_DATA;
                    else if (len_value > 16'(MAX_WORDS))
                        next_state = ST_ERROR;
                    else
                        next_state = ST_DAT_HI;
                end
            end
            ST_DAT_HI: if (accept) next_state = ST_DAT_LO;
            ST_DAT_LO: if (accept) next_state = (words_left == 16'd1) ? AFTER_DATA : ST_DAT_HI;
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHK: if (accept) next_state = (rx_data == csum) ? ST_DONE : ST_ERROR;
`endif
            default: next_state = ST_ERROR;
        endcase
    end

    // core_rst is released one cycle after DONE is reached, so the final write lands first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_hi     <= '0;
            words_left <= '0;
            imem_addr  <= START_ADDR;
            word_count <= '0;
            core_rst   <= CORE_RST_ACTIVE;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= next_state;
            core_rst <= ((state == ST_DONE) && (next_state == ST_DONE)) ? ~CORE_RST_ACTIVE
                                                                         : CORE_RST_ACTIVE;
            if (start_ok) begin
                imem_addr  <= START_ADDR;
                word_count <= '0;
                done       <= 1'b0;
                error      <= 1'b0;
            end else if (word_valid) begin
                imem_addr  <= imem_addr + 16'(PC_STRIDE);
                word_count <= word_count + 16'd1;
            end
            if ((next_state == ST_DONE) && (state != ST_DONE))
                done <= 1'b1;
            if ((next_state == ST_ERROR) && (state != ST_ERROR))
                error <= 1'b1;
            if (accept && (state == ST_LEN_HI))
                len_hi <= rx_data;
            if (accept && (state == ST_LEN_LO))
                words_left <= len_value;
            else if (lo_load)
                words_left <= words_left - 16'd1;
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Running XOR of every length and data byte, compared against the CHK byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (accept && (state != ST_CHK)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and random byte streams against
// a queue-based reference model. Honours BOOT_LOADER_CHECKSUM_EN when defined.
module tb_imem_boot_loader;

    localparam int          MAX_WORDS  = 256;
    localparam logic [15:0] START_ADDR = 16'h0;
    localparam int          PC_STRIDE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  tx_q[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] obs_addr[$];
    logic [15:0] obs_data[$];
    bit          exp_err;
    int          exp_count;
    int          last_we_cycle = 0;
    int          fall_cycle = 0;
    int          we_while_run = 0;
    logic        prev_core_rst = 1'b1;

    imem_boot_loader #(
        .MAX_WORDS  (MAX_WORDS),
        .START_ADDR (START_ADDR),
        .PC_STRIDE  (PC_STRIDE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Logs every memory write and the cycle in which core_rst last fell.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
            last_we_cycle = cyc;
            if (core_rst !== 1'b1) we_while_run++;
        end
        if (prev_core_rst === 1'b1 && core_rst === 1'b0) fall_cycle = cyc;
        prev_core_rst = core_rst;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_values();
        checkOutput("reset_flags", 32'({rx_ready, imem_we, core_rst, busy, done, error}), 32'(6'b001000));
        checkOutput("reset_addr", 32'(imem_addr), 32'(START_ADDR));
        checkOutput("reset_wdata", 32'(imem_wdata), 32'd0);
        checkOutput("reset_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rx_ready_timeout", 32'(waited < 20), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic build_stream(input int n);
        tx_q.delete();
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < 2 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
`ifdef BOOT_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                foreach (tx_q[i]) x ^= tx_q[i];
                tx_q.push_back(x);
            end
`endif
        end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic corrupt_checksum();
        tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'($urandom_range(1, 255));
    endtask
`endif

    // Reference: length prefix, big-endian word pairs at START_ADDR + PC_STRIDE*i.
    function automatic void build_expected();
        int n;
        exp_addr.delete();
        exp_data.delete();
        n         = int'({tx_q[0], tx_q[1]});
        exp_err   = (n > MAX_WORDS);
        exp_count = exp_err ? 0 : n;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(16'(int'(START_ADDR) + PC_STRIDE * i));
                exp_data.push_back({tx_q[2 + 2 * i], tx_q[3 + 2 * i]});
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < tx_q.size() - 1; i++) x ^= tx_q[i];
                exp_err = (x != tx_q[tx_q.size() - 1]);
            end
`endif
        end
    endfunction

    task automatic applyStimulus(input int gap_max, input bit poke_start);
        int waited = 0;
        build_expected();
        obs_addr.delete();
        obs_data.delete();
        we_while_run = 0;
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = tx_q[0];
        checkOutput("start_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        checkOutput("start_flags", 32'({busy, rx_ready, done, error, core_rst}), 32'(5'b11001));
        checkOutput("start_addr", 32'(imem_addr), 32'(START_ADDR));
        checkOutput("start_word_count", 32'(word_count), 32'd0);
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (poke_start && i == 3) start = 1'b1;
            send_byte(tx_q[i]);
            start = 1'b0;
        end
        while (!(done || error) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("finish_timeout", 32'(waited < 20), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("final_flags", 32'({done, error, busy, rx_ready}), 32'({~exp_err, exp_err, 2'b00}));
        checkOutput("final_core_rst", 32'(core_rst), 32'(exp_err));
        checkOutput("final_word_count", 32'(word_count), 32'(exp_count));
        checkOutput("write_count", 32'(obs_addr.size()), 32'(exp_addr.size()));
        checkOutput("write_while_core_run", 32'(we_while_run), 32'd0);
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            checkOutput("write_addr_data", {obs_addr[i], obs_data[i]}, {exp_addr[i], exp_data[i]});
        if (!exp_err && exp_addr.size() > 0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            checkOutput("core_rst_fall_after_write", 32'(fall_cycle > last_we_cycle), 32'd1);
`else
            checkOutput("core_rst_fall_cycle", 32'(fall_cycle), 32'(last_we_cycle + 1));
`endif
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
            checkOutput("idle_outputs", 32'({core_rst, rx_ready, done, error}), 32'(4'b1000));
        end
        rx_valid = 1'b0;

        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h42);
`endif
        applyStimulus(0, 1'b0);
        applyStimulus(5, 1'b1);

        build_stream(0);
        applyStimulus(2, 1'b0);
        tx_q = '{8'h01, 8'h01};
        applyStimulus(1, 1'b0);

        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h42);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(tx_q[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        applyStimulus(3, 1'b0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        applyStimulus(0, 1'b0);
        tx_q[4] = 8'h00;
        applyStimulus(0, 1'b0);
`endif

        for (int k = 0; k < 8; k++) begin
            build_stream(int'($urandom_range(1, 6)));
`ifdef BOOT_LOADER_CHECKSUM_EN
            if ((k % 3) == 2) corrupt_checksum();
`endif
            applyStimulus(int'($urandom_range(0, 5)), (k % 2) == 1);
        end

        build_stream(MAX_WORDS);
        applyStimulus(0, 1'b0);
        build_stream(int'($urandom_range(MAX_WORDS + 1, 65535)));
        applyStimulus(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
